// File: rtl/toggle_pkg.sv
// Shared types and defaults for the pushbutton toggle controller.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } tdc_state_t;

    localparam int unsigned TDC_DEBOUNCE_DEF = 16;
    localparam int unsigned TDC_CNT_W_DEF    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/toggle_debounce_ctrl.sv
// Debounces a raw pushbutton and turns each accepted press into a one-cycle
// T/enable pulse, tracking the expected latch state and a toggle count.
module toggle_debounce_ctrl
    import toggle_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = TDC_DEBOUNCE_DEF,
    parameter int unsigned CNT_W           = TDC_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic             hold,
    output logic             t_out,
    output logic             en_out,
    output logic             q_shadow,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             busy
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    tdc_state_t        state, state_n;
    logic [DCNT_W-1:0] cnt, cnt_n;
    logic              btn_s;
    logic              fire_c;
    logic              pulse_q;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Comparing cnt against DEBOUNCE_CYCLES-1 is the same test as cnt+1 == DEBOUNCE_CYCLES.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire_c  = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = DEB_PRESS;
                    cnt_n   = DCNT_ONE;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DCNT_LAST) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    fire_c  = ~hold;
                end else begin
                    cnt_n = cnt + DCNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_n = DEB_RELEASE;
                    cnt_n   = DCNT_ONE;
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == DCNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + DCNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // One flop drives both T and enable so the latch sees them with zero skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q    <= 1'b0;
            q_shadow   <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            pulse_q <= fire_c;
            if (fire_c) begin
                q_shadow   <= ~q_shadow;
                toggle_cnt <= toggle_cnt + CNT_W'(1);
            end
        end
    end

    assign t_out  = pulse_q;
    assign en_out = pulse_q;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_toggle_debounce_ctrl.sv
// Directed bench for toggle_debounce_ctrl with a run-length reference model.
module tb_toggle_debounce_ctrl;

    localparam int DEB = 4;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_in;
    logic          hold;
    logic          t_out, en_out, q_shadow, busy;
    logic [CW-1:0] toggle_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    toggle_debounce_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .hold       (hold),
        .t_out      (t_out),
        .en_out     (en_out),
        .q_shadow   (q_shadow),
        .toggle_cnt (toggle_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: the button is seen two samples late; a level change is accepted
    // after DEB consecutive samples disagreeing with the current accepted level.
    logic [1:0]    m_hist;
    logic          m_level, m_level_n;
    int            m_run, m_run_n;
    logic          m_fire_n;
    logic          m_t, m_q;
    logic [CW-1:0] m_cnt;

    always_comb begin
        m_level_n = m_level;
        m_run_n   = 0;
        m_fire_n  = 1'b0;
        if (m_hist[1] != m_level) begin
            if (m_run + 1 == DEB) begin
                m_level_n = ~m_level;
                m_fire_n  = ~m_level & ~hold;
            end else begin
                m_run_n = m_run + 1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist  <= 2'b00;
            m_level <= 1'b0;
            m_run   <= 0;
            m_t     <= 1'b0;
            m_q     <= 1'b0;
            m_cnt   <= '0;
        end else begin
            m_hist  <= {m_hist[0], btn_in};
            m_level <= m_level_n;
            m_run   <= m_run_n;
            m_t     <= m_fire_n;
            if (m_fire_n) begin
                m_q   <= ~m_q;
                m_cnt <= m_cnt + CW'(1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_t_out",  32'(t_out),      32'(m_t));
            chk("model_en_out", 32'(en_out),     32'(m_t));
            chk("model_q",      32'(q_shadow),   32'(m_q));
            chk("model_cnt",    32'(toggle_cnt), 32'(m_cnt));
            chk("model_busy",   32'(busy),       32'(m_level || (m_run != 0)));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic exp_q, input int exp_cnt);
        btn_in = 1'b1;
        repeat (DEB + 1) tick();
        chk("press_pre", 32'(t_out), 32'd0);
        tick();
        chk("press_t",   32'(t_out),      32'd1);
        chk("press_en",  32'(en_out),     32'd1);
        chk("press_q",   32'(q_shadow),   32'(exp_q));
        chk("press_cnt", 32'(toggle_cnt), 32'(exp_cnt));
        tick();
        chk("press_post", 32'(t_out), 32'd0);
        repeat (3) tick();
        btn_in = 1'b0;
        repeat (8) tick();
        chk("press_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;
        hold   = 1'b0;
        repeat (2) tick();
        chk("rst_t",    32'(t_out),      32'd0);
        chk("rst_q",    32'(q_shadow),   32'd0);
        chk("rst_cnt",  32'(toggle_cnt), 32'd0);
        chk("rst_busy", 32'(busy),       32'd0);
        #2 rst = 1'b0;

        // clean press held 20 cycles
        btn_in = 1'b1;
        repeat (5) tick();
        chk("clean_e5", 32'(t_out), 32'd0);
        tick();
        chk("clean_t",   32'(t_out),      32'd1);
        chk("clean_en",  32'(en_out),     32'd1);
        chk("clean_q",   32'(q_shadow),   32'd1);
        chk("clean_cnt", 32'(toggle_cnt), 32'd1);
        repeat (14) tick();
        chk("clean_held_t",    32'(t_out),      32'd0);
        chk("clean_held_busy", 32'(busy),       32'd1);
        chk("clean_held_cnt",  32'(toggle_cnt), 32'd1);
        btn_in = 1'b0;
        repeat (8) tick();
        chk("clean_rel_busy", 32'(busy),     32'd0);
        chk("clean_rel_q",    32'(q_shadow), 32'd1);

        // bouncy press 1,1,0,1,1,...
        btn_in = 1'b1;
        tick();
        tick();
        btn_in = 1'b0;
        tick();
        btn_in = 1'b1;
        repeat (5) tick();
        chk("bounce_e8", 32'(t_out), 32'd0);
        tick();
        chk("bounce_t",   32'(t_out),      32'd1);
        chk("bounce_q",   32'(q_shadow),   32'd0);
        chk("bounce_cnt", 32'(toggle_cnt), 32'd2);
        repeat (4) tick();
        btn_in = 1'b0;
        repeat (8) tick();
        chk("bounce_idle", 32'(busy), 32'd0);

        // hold suppresses the qualifying edge and is not replayed
        hold   = 1'b1;
        btn_in = 1'b1;
        repeat (6) tick();
        chk("hold_t",    32'(t_out),      32'd0);
        chk("hold_busy", 32'(busy),       32'd1);
        chk("hold_q",    32'(q_shadow),   32'd0);
        chk("hold_cnt",  32'(toggle_cnt), 32'd2);
        hold = 1'b0;
        repeat (3) tick();
        chk("hold_noreplay", 32'(t_out), 32'd0);
        chk("hold_pressed",  32'(busy),  32'd1);
        btn_in = 1'b0;
        repeat (8) tick();
        chk("hold_idle", 32'(busy), 32'd0);
        press(1'b1, 3);

        // release glitch of two cycles returns to PRESSED without a pulse
        btn_in = 1'b1;
        repeat (8) tick();
        chk("relb_q",   32'(q_shadow),   32'd0);
        chk("relb_cnt", 32'(toggle_cnt), 32'd0);
        btn_in = 1'b0;
        tick();
        tick();
        btn_in = 1'b1;
        repeat (6) tick();
        chk("relb_busy", 32'(busy),       32'd1);
        chk("relb_t",    32'(t_out),      32'd0);
        chk("relb_cnt2", 32'(toggle_cnt), 32'd0);
        btn_in = 1'b0;
        repeat (8) tick();
        chk("relb_idle", 32'(busy), 32'd0);
        press(1'b1, 1);

        // async reset in the middle of a press debounce
        btn_in = 1'b1;
        repeat (3) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_t",    32'(t_out),      32'd0);
        chk("arst_en",   32'(en_out),     32'd0);
        chk("arst_q",    32'(q_shadow),   32'd0);
        chk("arst_cnt",  32'(toggle_cnt), 32'd0);
        chk("arst_busy", 32'(busy),       32'd0);
        tick();
        tick();
        #2 rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_e5", 32'(t_out), 32'd0);
        tick();
        chk("post_rst_t",   32'(t_out),      32'd1);
        chk("post_rst_q",   32'(q_shadow),   32'd1);
        chk("post_rst_cnt", 32'(toggle_cnt), 32'd1);
        repeat (4) tick();
        btn_in = 1'b0;
        repeat (8) tick();

        // count wrap with a 2-bit counter: continues 2,3,0,1
        press(1'b0, 2);
        press(1'b1, 3);
        press(1'b0, 0);
        press(1'b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_debounce_ctrl.md
# toggle_debounce_ctrl

Upstream control stage for the level-enabled T latch. Samples a raw asynchronous pushbutton, synchronises and debounces it, and converts each debounced press into a single-cycle toggle request (`t_out`) with a matching single-cycle enable window (`en_out`). It also keeps a shadow copy of the expected latch state and a running toggle count.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a press or a release. Legal range is 2 or more.
- `CNT_W`, default 8: width of `toggle_cnt`.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `btn_in`, input, 1: raw button, asynchronous to `clk`, may bounce.
- `hold`, input, 1: synchronous suppress; blocks toggle generation.
- `t_out`, output, 1: toggle request to the latch T input, one-cycle pulse.
- `en_out`, output, 1: enable to the latch's level enable; always identical to `t_out`.
- `q_shadow`, output, 1: expected latch Q; inverts on each issued pulse.
- `toggle_cnt`, output, CNT_W: number of issued pulses, modulo 2^CNT_W.
- `busy`, output, 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** two flops, both reset to 0. The FSM sees only the second stage, `btn_s`.
- **FSM states:** IDLE, DEB_PRESS, PRESSED, DEB_RELEASE. Debounce counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
- **IDLE:** if `btn_s`=1, go to DEB_PRESS with `cnt`=1.
- **DEB_PRESS:**
  - `btn_s`=0: bounce; return to IDLE with `cnt`=0.
  - Otherwise, if `cnt`+1 equals `DEBOUNCE_CYCLES`, go to PRESSED and issue a pulse, unless `hold`=1.
  - Otherwise increment `cnt`.
- **PRESSED:** if `btn_s`=0, go to DEB_RELEASE with `cnt`=1.
- **DEB_RELEASE:** mirror of DEB_PRESS.
  - `btn_s`=1: return to PRESSED.
  - Reaching `DEBOUNCE_CYCLES` goes to IDLE.
  - Release never issues a pulse.
- **Issuing a pulse:** all registered on the same edge:
  - `t_out`=`en_out`=1 for exactly one cycle.
  - `q_shadow` inverts.
  - `toggle_cnt` increments, wrapping from 2^CNT_W−1 to 0.
- **hold:**
  - Sampled only on the edge where a pulse would be issued.
  - When `hold`=1 on that edge, the FSM still enters PRESSED, but there is no pulse, no shadow change and no count.
  - A suppressed press is never replayed.
- **Pulse spacing:** at most one pulse per press/release cycle, so `t_out` is never high on two consecutive cycles.
- **busy:** combinational decode of state != IDLE.
- **Reset (async, any time):**
  - State goes to IDLE; `cnt`, the sync flops, `t_out`, `en_out`, `q_shadow` and `toggle_cnt` all go to 0.
  - A press in flight is discarded.
  - A button held through reset deassertion is treated as a new press.

## Timing
- Latency with `btn_in` stable high from edge 1:
  - `btn_s`=1 after edge 2.
  - IDLE→DEB_PRESS at edge 3.
  - `t_out` high after edge `DEBOUNCE_CYCLES`+2, for one cycle.
- Example: `DEBOUNCE_CYCLES`=4 gives `t_out` high in the cycle following edge 6.
- A bounce (`btn_s` low for one cycle) inside DEB_PRESS restarts the full debounce window.
- `en_out` and `t_out` are flop outputs from the same register, so they carry no glitch and no skew. The downstream latch therefore sees T and enable high together for exactly one clock period.
- `q_shadow` and `toggle_cnt` update on the same edge that raises `t_out`.

## Structure
- **Package `toggle_pkg`:**
  - State enum `tdc_state_t` (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE).
  - Default debounce constant `TDC_DEBOUNCE_DEF`=16.
- **Sub-module `sync_2ff`:** 1-bit two-flop synchroniser with async active-high reset, ports `clk`, `rst`, `d`, `q`. It is instantiated once and is reusable elsewhere.
- **Remaining logic:** FSM, counter and output registers stay in the top module.

## Test plan
- **Reset:** with `DEBOUNCE_CYCLES`=4, assert `rst` mid-DEB_PRESS → all outputs 0 immediately (async), `busy`=0. After release, a held button yields `t_out` after edge 6 counted from reset deassertion.
- **Clean press:** `btn_in` held high 20 cycles → single `t_out`/`en_out` pulse after edge 6, `q_shadow` 0→1, `toggle_cnt`=1. No second pulse on release.
- **Bouncy press:** `btn_in` pattern 1,1,0,1,1,1,1,… → the bounce restarts the window; pulse comes 4 stable `btn_s` cycles after the last low, and exactly one pulse is issued.
- **hold:**
  - `hold`=1 across the qualifying edge → no pulse, `q_shadow`/`toggle_cnt` unchanged, FSM in PRESSED (`busy`=1).
  - The next clean press with `hold`=0 pulses normally.
- **Wrap:** with `CNT_W`=2, apply 5 clean presses → `toggle_cnt` sequence 1,2,3,0,1 and `q_shadow` 1,0,1,0,1.
- **Release bounce:** glitch low for 2 cycles while PRESSED → return to PRESSED with no pulse. A true release of 4+ stable cycles → IDLE, `busy`=0.
